// File: rtl/piso_tx_if.sv
// piso_tx_if: handshake and serial-side signals of the piso_tx transmitter.
//   din        parallel word offered to the transmitter
//   din_valid  din holds a word to send
//   din_ready  transmitter can take a word this cycle
//   sout       serial data, LSB first
//   sout_valid sout carries a frame bit
//   busy       transmitter is shifting a word
//   done       last bit of a word is on sout
// master: word producer / serial consumer side; slave: the transmitter.
interface piso_tx_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   modport master (
      output din, din_valid,
      input  din_ready, sout, sout_valid, busy, done
   );

   modport slave (
      input  din, din_valid,
      output din_ready, sout, sout_valid, busy, done
   );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter. Takes a WIDTH-bit word over a
// valid/ready handshake and shifts it out LSB first, one bit per clock, with
// a one-cycle done strobe on the last bit. A word offered on the last-bit
// cycle is accepted directly, so back-to-back words stream with no gap.
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous reset, active low
//   bus  piso_tx_if slave modport (din/din_valid/din_ready,
//        sout/sout_valid/busy/done)
module piso_tx #(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   piso_tx_if.slave   bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  shreg;
   logic [CW-1:0]     cnt;
   logic              last_bit;
   logic              accept;

   assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
   // rst gates ready so nothing is offered while reset is held
   assign accept   = bus.din_valid && bus.din_ready;

   // state register and datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            shreg <= bus.din;
            cnt   <= '0;
         end else if (state == SHIFT) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            cnt   <= last_bit ? '0 : cnt + CW'(1);
         end
      end
   end

   // next state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = SHIFT;
         SHIFT:   if (last_bit && !accept) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      bus.din_ready  = rst && ((state == IDLE) || last_bit);
      bus.sout       = 1'b0;
      bus.sout_valid = 1'b0;
      bus.busy       = 1'b0;
      bus.done       = last_bit;
      if (state == SHIFT) begin
         bus.sout       = shreg[0];
         bus.sout_valid = 1'b1;
         bus.busy       = 1'b1;
      end
   end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx at WIDTH=4. Output vector checked
// each cycle is {sout, sout_valid, busy, done, din_ready}.
module tb_piso_tx;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] lb;
   int         n_chk  = 0;
   int         n_pass = 0;

   piso_tx_if #(.WIDTH(4)) bus ();

   piso_tx #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // loopback: right-shifting serial-in register fed by sout
   always_ff @(posedge clk) lb <= {bus.sout, lb[3:1]};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [4:0] outs();
      return {bus.sout, bus.sout_valid, bus.busy, bus.done, bus.din_ready};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after the accept edge. Checks the four bit cycles of word w.
   // noise drives din_valid=1/din=F during bits 0..2 (must be ignored);
   // chain offers nxt on the last-bit cycle.
   task automatic frame(input string tag, input logic [3:0] w, input bit noise,
                        input bit chain, input logic [3:0] nxt);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_bit%0d", tag, k), outs(),
               {w[k], 1'b1, 1'b1, (k == 3), (k == 3)});
         if (k < 3) begin
            bus.din_valid = noise;
            bus.din       = 4'hF;
         end else begin
            bus.din_valid = chain;
            bus.din       = nxt;
         end
         tick();
      end
      bus.din_valid = 1'b0;
   endtask

   task automatic send(input logic [3:0] w);
      bus.din       = w;
      bus.din_valid = 1'b1;
      tick();
      bus.din_valid = 1'b0;
   endtask

   initial begin
      rst           = 1'b0;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      #3;
      check("reset_outs", outs(), 5'b00000);

      @(negedge clk);
      rst = 1'b1;
      #1;
      check("release_ready", outs(), 5'b00001);

      // idle line
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("idle%0d", i), outs(), 5'b00001);
      end

      // single word with loopback
      send(4'b1011);
      frame("single", 4'b1011, 1'b0, 1'b0, 4'h0);
      check("loopback", 32'(lb), 32'hB);
      check("single_idle", outs(), 5'b00001);

      // back-to-back
      send(4'hA);
      frame("b2b_a", 4'hA, 1'b0, 1'b1, 4'h5);
      frame("b2b_5", 4'h5, 1'b0, 1'b0, 4'h0);
      check("b2b_idle", outs(), 5'b00001);

      // busy ignore, valid dropped before last bit
      send(4'h0);
      frame("ign", 4'h0, 1'b1, 1'b0, 4'h0);
      check("ign_idle", outs(), 5'b00001);

      // busy ignore, valid still high on last bit: F follows
      send(4'h0);
      frame("ign2", 4'h0, 1'b1, 1'b1, 4'hF);
      frame("ign2_f", 4'hF, 1'b0, 1'b0, 4'h0);
      check("ign2_idle", outs(), 5'b00001);

      // reset mid-frame during bit 2
      send(4'hF);
      check("rmf_bit0", outs(), 5'b11100);
      tick();
      tick();
      check("rmf_bit2", outs(), 5'b11100);
      #2;
      rst = 1'b0;
      #1;
      check("rmf_async", outs(), 5'b00000);
      tick();
      check("rmf_held", outs(), 5'b00000);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rmf_release", outs(), 5'b00001);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rmf_quiet%0d", i), outs(), 5'b00001);
      end

      // reset with valid held
      @(negedge clk);
      rst           = 1'b0;
      bus.din       = 4'h6;
      bus.din_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("rv_held%0d", i), outs(), 5'b00000);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rv_release", outs(), 5'b00001);
      tick();
      bus.din_valid = 1'b0;
      frame("rv", 4'h6, 1'b0, 1'b0, 4'h0);
      check("rv_idle", outs(), 5'b00001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, LSB first, with a framing strobe. It is the transmit end of the serial shift-register link. A right-shifting serial-in register clocked on the same `clk` with `d = sout` holds the original word after WIDTH shifts. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 4: word length in bits; legal range is 2 or more.

- `clk`  in  1  sole clock; all flops update on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Asserted means `rst`=0.
- `din`  in  WIDTH  parallel word to transmit; sampled only on an accept edge.
- `din_valid`  in  1  `din` holds a word to send.
- `din_ready`  out  1  transmitter can take a word this cycle. Combinational: `rst` & (state==IDLE | last_bit).
- `sout`  out  1  serial data, LSB first; 0 when idle.
- `sout_valid`  out  1  `sout` carries a frame bit this cycle.
- `busy`  out  1  state==SHIFT.
- `done`  out  1  one-cycle pulse, high in the cycle the last bit of a word is on `sout`.

## Operation
- Internal state:
  - `shreg[WIDTH-1:0]`: shift register.
  - `cnt[$clog2(WIDTH)-1:0]`: bit index.
  - FSM with states IDLE and SHIFT.
- Accept: `din_valid` & `din_ready` at a rising edge.
- IDLE:
  - `din_ready`=1, `sout`=0, `sout_valid`=0.
  - On accept: `shreg`←`din`, `cnt`←0, go to SHIFT.
- SHIFT:
  - `sout`=`shreg[0]`, `sout_valid`=1.
  - Each edge: `shreg`←{1'b0, `shreg[WIDTH-1:1]`}, `cnt`←`cnt`+1.
- last_bit = (state==SHIFT) & (`cnt`==WIDTH-1). `done`=last_bit, `din_ready`=1.
- Edge with last_bit set:
  - With accept: `shreg`←`din`, `cnt`←0, stay in SHIFT. This is gap-free streaming.
  - Without accept: return to IDLE.
- `din_valid` while `din_ready`=0 is ignored. Mid-frame words are not captured or queued, and the in-flight frame is unaffected.
- `cnt` never exceeds WIDTH-1 and never wraps inside a frame. It always restarts at 0 on accept.
- `din` is not required to be stable after the accept edge.

## Timing
- Reset values, applied immediately on `rst` falling, independent of `clk`:
  - state=IDLE, `shreg`=0, `cnt`=0.
  - `sout`=0, `sout_valid`=0, `busy`=0, `done`=0.
  - `din_ready`=0 while `rst`=0.
- Reset release: `din_ready`=1 in the first cycle `rst`=1. The first accept is possible at the first rising edge after release.
- Latency: for an accept at edge E, bit k (k=0..WIDTH-1) is on `sout` in the cycle after edge E+k.
  - `sout_valid` is high for exactly WIDTH cycles per word.
  - `done` is high in the cycle after edge E+WIDTH-1.
- Throughput:
  - Continuous streaming: one word per WIDTH cycles.
  - Separate words (IDLE between them): WIDTH+1 cycles minimum, since the next accept happens in IDLE.
- Reset mid-frame:
  - The frame is aborted, and all outputs go to reset values asynchronously.
  - No partial frame resumes after release, and no `done` pulse is produced for the aborted word.

## Test plan
- Single word, WIDTH=4:
  - Stimulus: `din`=4'b1011 accepted at edge E.
  - Response: `sout`=1,1,0,1 in the cycles after E..E+3, `sout_valid` high 4 cycles, `done` high only in the 4th.
  - Loopback: a right-shifting serial-in register with `d=sout`, clocked on `clk`, shows q=4'b1011 one edge after `done`.
- Back-to-back:
  - Stimulus: 4'hA, then 4'h5 accepted on the last-bit cycle (`din_ready`=1 there).
  - Response: `sout`=0,1,0,1,1,0,1,0 with `sout_valid` continuous for 8 cycles and `done` pulsing at bits 4 and 8.
- Busy ignore:
  - Stimulus: `din_valid`=1 with `din`=4'hF during bits 1–3 of 4'h0.
  - Response: `sout`=0,0,0,0. 4'hF is sent only if `din_valid` is still high in the last-bit cycle.
- Reset mid-frame:
  - Stimulus: drop `rst` during bit 2 of 4'b1111, between edges.
  - Response: `sout`, `sout_valid`, `busy` and `done` go to 0 immediately, `din_ready`=0. After release: IDLE, `din_ready`=1, no residual bits.
- Reset with valid held:
  - Stimulus: `din_valid`=1 with `din`=4'h6 throughout reset.
  - Response: no accept while `rst`=0. The word is accepted at the first edge after release, and `sout`=0,1,1,0 follows.
- Idle line:
  - Stimulus: 10 cycles with `din_valid`=0 after reset.
  - Response: `sout`=0, `sout_valid`=0, `busy`=0, `done`=0, `din_ready`=1 throughout.
